// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronises rxd, validates start bits, majority-votes each bit mid-cell,
// and holds LSB-first words behind a valid/ack register. Optional parity stage: define UART_RX_PARITY_EN.
module uart_rx_os #(
    parameter int DATABITS    = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ODD_PARITY  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                rxd,
    input  logic                rx_ack,
    output logic [DATABITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                rx_ferr,
    output logic                rx_perr,
    output logic                rx_ovr,
    output logic                busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATABITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_V0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BITS_ALL = BW'(DATABITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bitcnt_q;
    logic [1:0]             samp_q;
    logic [DATABITS-1:0]    shift_q;
    logic                   commit_q, cferr_q, busy_q;
    logic [DATABITS-1:0]    rx_data_q;
    logic                   rx_valid_q, ferr_q, ovr_q;
    logic                   rxd_s, vote, is_dec, is_last;

    assign rxd_s   = sync_q[SYNC_STAGES-1];
    assign is_dec  = (cnt_q == CNT_DEC);
    assign is_last = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = is_last ? '0 : cnt_q + 1'b1;
        vote  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
    end

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end

    // The third vote is the live synchronised sample taken at the decision tick.
    always_ff @(posedge clk) begin
        if (tick && cnt_q == CNT_V0) samp_q[0] <= rxd_s;
        if (tick && cnt_q == CNT_V1) samp_q[1] <= rxd_s;
        if (tick && state_q == S_DATA && is_dec) shift_q <= {vote, shift_q[DATABITS-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    logic cperr_q, perr_q;
    localparam logic ODD = 1'(ODD_PARITY);
`else
    logic unused_odd;
    assign unused_odd = 1'(ODD_PARITY);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            commit_q <= 1'b0;
            cferr_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            cperr_q  <= 1'b0;
`endif
        end else begin
            commit_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    S_IDLE: if (!rxd_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                    S_START: begin
                        cnt_q <= cnt_d;
                        if (is_dec && vote) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else if (is_last) begin
                            state_q  <= S_DATA;
                            bitcnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            cperr_q  <= 1'b0;
`endif
                        end
                    end
                    S_DATA: begin
                        cnt_q <= cnt_d;
                        if (is_dec) bitcnt_q <= bitcnt_q + 1'b1;
                        if (is_last && bitcnt_q == BITS_ALL) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        cnt_q <= cnt_d;
                        if (is_dec) cperr_q <= vote ^ (^shift_q) ^ ODD;
                        if (is_last) state_q <= S_STOP;
                    end
`endif
                    // Stop is decided mid-cell so the next start edge is never missed.
                    S_STOP: begin
                        cnt_q <= cnt_d;
                        if (is_dec) begin
                            commit_q <= 1'b1;
                            cferr_q  <= ~vote;
                            state_q  <= vote ? S_IDLE : S_BREAK;
                            busy_q   <= ~vote;
                        end
                    end
                    S_BREAK: if (rxd_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else if (commit_q) begin
            rx_data_q  <= shift_q;
            rx_valid_q <= 1'b1;
            ferr_q     <= cferr_q;
            ovr_q      <= rx_valid_q & ~rx_ack;
`ifdef UART_RX_PARITY_EN
            perr_q     <= cperr_q;
`endif
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_ferr  = ferr_q;
    assign rx_ovr   = ovr_q;
    assign busy     = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_perr  = perr_q;
`else
    assign rx_perr  = 1'b0;
`endif
endmodule
